// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// first-word-fall-through FIFO with sticky frame/overrun error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 218,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t state, state_n;

  logic          sync1, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_q;

  logic cnt_clr, shift_en, push_set, ferr_set, idx_clr;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push, ov_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push_set = 1'b0;
    ferr_set = 1'b0;
    idx_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
        if (!rxs) state_n = START;
      end
      START: begin
        idx_clr = 1'b1;
        if (cnt == HALF) begin
          cnt_clr = 1'b1;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            push_set = 1'b1;
            state_n  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
    end else begin
      cnt     <= cnt_clr ? '0 : cnt + 1'b1;
      push_q  <= push_set;
      if (idx_clr) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
    end
  end

  // A full FIFO still accepts a byte when the head leaves the same cycle.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);
  assign pop    = rd_en && !empty;
  assign push   = push_q && (!full || pop);
  assign ov_set = push_q && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set || (frame_err && !clear_err);
      overrun   <= ov_set || (overrun && !clear_err);
    end
  end

  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign rx_valid  = !empty;
  assign fifo_full = full;

endmodule
